// File: rtl/can_rx_bit_sched.sv
// CAN receive bit-timing scheduler: hard sync on SOF, one sample strobe per bit, destuff
// tracking and end-of-frame / error-recovery detection. Soft resync needs CAN_RX_SOFT_RESYNC_EN.
module can_rx_bit_sched #(
    parameter int CLK_FREQ_MHZ  = 100,
    parameter int BIT_RATE_KBPS = 1000,
    parameter int SAMPLE_PCT    = 75,
    parameter int SJW_CLK       = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic can_rx,
    input  logic sof_detect,
    input  logic destuff_dis,
    output logic sample_en,
    output logic rx_bit,
    output logic stuff_bit,
    output logic stuff_err,
    output logic frame_done,
    output logic busy
);
    localparam int CPB = (CLK_FREQ_MHZ * 1000) / BIT_RATE_KBPS;
    localparam int SP  = (CPB * SAMPLE_PCT) / 100;
    localparam int TQW = $clog2(CPB + 1);

    localparam logic [TQW-1:0] TQ_ZERO = {TQW{1'b0}};
    localparam logic [TQW-1:0] TQ_ONE  = TQW'(1);
    localparam logic [TQW-1:0] TQ_LAST = TQW'(CPB - 1);
    localparam logic [TQW-1:0] TQ_CPB  = TQW'(CPB);
    localparam logic [TQW-1:0] TQ_SP   = TQW'(SP);
    localparam logic [TQW-1:0] TQ_SJW  = TQW'(SJW_CLK);
    localparam logic [3:0]     REC_SAT = 4'd11;

`ifdef CAN_RX_SOFT_RESYNC_EN
    localparam logic RESYNC_EN = 1'b1;
`else
    localparam logic RESYNC_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_ERR  = 2'b10
    } state_t;

    state_t         state_r, state_s;
    logic [TQW-1:0] tq_cnt_r, tq_next_s;
    logic [TQW-1:0] late_jump_s, late_s;
    logic [TQW-1:0] early_room_s, early_jump_s, early_sum_s, early_s;
    logic [2:0]     run_cnt_r, run_cnt_s;
    logic           run_val_r, run_val_s;
    logic [3:0]     rec_cnt_r, rec_cnt_s;
    logic           resync_done_r, resync_done_s;
    logic           prev_rx_r, edge_s;
    logic           sample_s, rx_bit_s, stuff_bit_s, stuff_err_s, frame_done_s;
    logic           sample_en_r, rx_bit_r, stuff_bit_r, stuff_err_r, frame_done_r, busy_r;

    // Resync candidates: late edge pulls tq back, early edge pushes it toward the next bit.
    // Both already include the +1 of the current clock.
    assign edge_s       = prev_rx_r & ~can_rx & rx_bit_r & ~resync_done_r & (tq_cnt_r != TQ_ZERO);
    assign late_jump_s  = (tq_cnt_r < TQ_SJW) ? tq_cnt_r : TQ_SJW;
    assign late_s       = tq_cnt_r - late_jump_s + TQ_ONE;
    assign early_room_s = TQ_CPB - tq_cnt_r;
    assign early_jump_s = (early_room_s < TQ_SJW) ? early_room_s : TQ_SJW;
    assign early_sum_s  = tq_cnt_r + early_jump_s;
    assign early_s      = (early_sum_s >= TQ_LAST) ? (early_sum_s - TQ_LAST) : (early_sum_s + TQ_ONE);

    // Next-state, bit timing and per-sample decode
    always_comb begin
        state_s       = state_r;
        tq_next_s     = (tq_cnt_r == TQ_LAST) ? TQ_ZERO : (tq_cnt_r + TQ_ONE);
        run_cnt_s     = run_cnt_r;
        run_val_s     = run_val_r;
        rec_cnt_s     = rec_cnt_r;
        resync_done_s = resync_done_r;
        sample_s      = 1'b0;
        rx_bit_s      = rx_bit_r;
        stuff_bit_s   = 1'b0;
        stuff_err_s   = 1'b0;
        frame_done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                tq_next_s = TQ_ZERO;
                if (sof_detect) begin
                    state_s       = ST_RUN;
                    tq_next_s     = TQ_ONE;   // the SOF cycle itself is clock 0
                    run_cnt_s     = 3'd0;
                    run_val_s     = 1'b0;
                    rec_cnt_s     = 4'd0;
                    resync_done_s = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN, ST_ERR: begin
                if (tq_cnt_r == TQ_SP) begin
                    sample_s      = 1'b1;
                    rx_bit_s      = can_rx;
                    resync_done_s = 1'b0;
                    rec_cnt_s     = can_rx ? ((rec_cnt_r == REC_SAT) ? REC_SAT : (rec_cnt_r + 4'd1)) : 4'd0;
                    if ((state_r == ST_RUN) && !destuff_dis) begin
                        if (run_cnt_r == 3'd5) begin
                            if (can_rx != run_val_r) begin
                                stuff_bit_s = 1'b1;
                                run_cnt_s   = 3'd1;
                                run_val_s   = can_rx;
                            end else begin
                                stuff_err_s = 1'b1;
                                state_s     = ST_ERR;
                            end
                        end else if ((run_cnt_r != 3'd0) && (can_rx == run_val_r)) begin
                            run_cnt_s = run_cnt_r + 3'd1;
                        end else begin
                            run_cnt_s = 3'd1;
                            run_val_s = can_rx;
                        end
                    end else begin
                        run_cnt_s = run_cnt_r;
                    end
                    // 11th consecutive recessive sample closes a frame or ends error recovery
                    if (can_rx && (rec_cnt_r >= 4'd10)) begin
                        if (state_r == ST_ERR) begin
                            state_s   = ST_IDLE;
                            tq_next_s = TQ_ZERO;
                        end else if (destuff_dis) begin
                            frame_done_s = 1'b1;
                            state_s      = ST_IDLE;
                            tq_next_s    = TQ_ZERO;
                        end else begin
                            frame_done_s = 1'b0;
                        end
                    end else begin
                        frame_done_s = 1'b0;
                    end
                end else if (RESYNC_EN && (state_r == ST_RUN) && edge_s) begin
                    resync_done_s = 1'b1;
                    tq_next_s     = (tq_cnt_r < TQ_SP) ? late_s : early_s;
                end else begin
                    resync_done_s = resync_done_r;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                tq_next_s = TQ_ZERO;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            tq_cnt_r      <= TQ_ZERO;
            run_cnt_r     <= 3'd0;
            run_val_r     <= 1'b0;
            rec_cnt_r     <= 4'd0;
            resync_done_r <= 1'b0;
            prev_rx_r     <= 1'b1;
            sample_en_r   <= 1'b0;
            rx_bit_r      <= 1'b1;
            stuff_bit_r   <= 1'b0;
            stuff_err_r   <= 1'b0;
            frame_done_r  <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            tq_cnt_r      <= tq_next_s;
            run_cnt_r     <= run_cnt_s;
            run_val_r     <= run_val_s;
            rec_cnt_r     <= rec_cnt_s;
            resync_done_r <= resync_done_s;
            prev_rx_r     <= can_rx;
            sample_en_r   <= sample_s;
            rx_bit_r      <= rx_bit_s;
            stuff_bit_r   <= stuff_bit_s;
            stuff_err_r   <= stuff_err_s;
            frame_done_r  <= frame_done_s;
            // held one extra cycle on the way out so busy drops after the final strobe
            busy_r        <= (state_r != ST_IDLE) || (state_s != ST_IDLE);
        end
    end

    assign sample_en  = sample_en_r;
    assign rx_bit     = rx_bit_r;
    assign stuff_bit  = stuff_bit_r;
    assign stuff_err  = stuff_err_r;
    assign frame_done = frame_done_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_can_rx_bit_sched.sv
// Directed self-checking bench for can_rx_bit_sched at default timing (CPB=100, SP=75, SJW=10).
module tb_can_rx_bit_sched;
    localparam int NCYC = 2048;

    logic clk = 1'b0;
    logic rst, can_rx, sof_detect, destuff_dis;
    logic sample_en, rx_bit, stuff_bit, stuff_err, frame_done, busy;

    always #5 clk = ~clk;

    can_rx_bit_sched dut (
        .clk        (clk),
        .rst        (rst),
        .can_rx     (can_rx),
        .sof_detect (sof_detect),
        .destuff_dis(destuff_dis),
        .sample_en  (sample_en),
        .rx_bit     (rx_bit),
        .stuff_bit  (stuff_bit),
        .stuff_err  (stuff_err),
        .frame_done (frame_done),
        .busy       (busy)
    );

    logic lvl    [NCYC];
    logic sofv   [NCYC];
    logic ddv    [NCYC];
    logic rstv   [NCYC];
    logic busy_a [NCYC];
    int   st_q[$];
    logic rxb_q[$], sb_q[$], serr_q[$], fd_q[$];
    int   se_any, fd_any;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic init_vec();
        for (int i = 0; i < NCYC; i++) begin
            lvl[i] = 1'b1; sofv[i] = 1'b0; ddv[i] = 1'b0; rstv[i] = 1'b0; busy_a[i] = 1'b0;
        end
        st_q.delete(); rxb_q.delete(); sb_q.delete(); serr_q.delete(); fd_q.delete();
        se_any = 0; fd_any = 0;
    endtask

    task automatic set_range(input int a, input int b, input logic v);
        for (int i = a; i <= b; i++) lvl[i] = v;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; sof_detect = 1'b0; can_rx = 1'b1; destuff_dis = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Cycle c of the vectors is driven after posedge c and observed at the following negedge
    task automatic play(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            rst = rstv[c]; can_rx = lvl[c]; sof_detect = sofv[c]; destuff_dis = ddv[c];
            @(negedge clk);
            busy_a[c] = busy;
            if (sample_en === 1'b1) begin
                st_q.push_back(c); rxb_q.push_back(rx_bit); sb_q.push_back(stuff_bit);
                serr_q.push_back(stuff_err); fd_q.push_back(frame_done);
            end
            if (stuff_err === 1'b1) se_any++;
            if (frame_done === 1'b1) fd_any++;
        end
        @(posedge clk); #1;
        rst = 1'b0; sof_detect = 1'b0; can_rx = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            sof_detect = i[0];
            @(negedge clk);
            n_checks++;
            if ({sample_en, rx_bit, stuff_bit, stuff_err, frame_done, busy} !== 6'b010000) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got %b expected 010000", i,
                         {sample_en, rx_bit, stuff_bit, stuff_err, frame_done, busy});
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; sof_detect = 1'b0; can_rx = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({sample_en, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_release: got sample_en/busy %b expected 00", {sample_en, busy});
        end
    endtask

    task automatic test_nominal(input logic extra_sof);
        init_vec();
        sofv[0] = 1'b1;
        if (extra_sof) sofv[150] = 1'b1;
        set_range(0, 99, 1'b0); set_range(100, 199, 1'b1);
        set_range(200, 299, 1'b0); set_range(300, 399, 1'b1);
        do_reset();
        play(400);
        n_checks++;
        if (st_q.size() != 4) begin
            n_fail++; $display("FAIL nominal_count: got %0d expected 4", st_q.size());
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ((k < st_q.size() ? st_q[k] : -1) != 76 + 100 * k) begin
                n_fail++;
                $display("FAIL nominal_strobe%0d: got %0d expected %0d", k,
                         (k < st_q.size() ? st_q[k] : -1), 76 + 100 * k);
            end
            n_checks++;
            if ((k < rxb_q.size() ? rxb_q[k] : 1'bx) !== ((k % 2 == 1) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL nominal_rx_bit%0d: got %b expected %0d", k,
                         (k < rxb_q.size() ? rxb_q[k] : 1'bx), k % 2);
            end
        end
        n_checks++;
        if ({busy_a[0], busy_a[1], busy_a[399]} !== 3'b011) begin
            n_fail++;
            $display("FAIL nominal_busy: got %b expected 011", {busy_a[0], busy_a[1], busy_a[399]});
        end
    endtask

    task automatic test_stuff_bit();
        int sb_early;
        init_vec();
        sofv[0] = 1'b1;
        set_range(0, 499, 1'b0);
        do_reset();
        play(600);
        sb_early = 0;
        for (int k = 0; k < 5 && k < sb_q.size(); k++) if (sb_q[k] !== 1'b0) sb_early++;
        n_checks++;
        if (st_q.size() != 6 || st_q[5] != 576) begin
            n_fail++; $display("FAIL stuff_strobes: got count %0d expected 6 with last at 576", st_q.size());
        end
        n_checks++;
        if ((st_q.size() > 5 ? {sb_q[5], rxb_q[5]} : 2'bxx) !== 2'b11) begin
            n_fail++;
            $display("FAIL stuff_bit6: got stuff/rx %b expected 11", (st_q.size() > 5 ? {sb_q[5], rxb_q[5]} : 2'bxx));
        end
        n_checks++;
        if (sb_early != 0 || se_any != 0) begin
            n_fail++; $display("FAIL stuff_spurious: got %0d early stuff, %0d errors expected 0", sb_early, se_any);
        end
    endtask

    task automatic test_stuff_err();
        init_vec();
        sofv[0] = 1'b1;
        set_range(0, 599, 1'b0);
        do_reset();
        play(1750);
        n_checks++;
        if ((st_q.size() > 5 ? {serr_q[5], 10'(st_q[5])} : 11'h7ff) !== {1'b1, 10'd576}) begin
            n_fail++; $display("FAIL stuff_err_pulse: got pulse/cycle mismatch, count %0d expected 1 at 576", se_any);
        end
        n_checks++;
        if (se_any != 1 || fd_any != 0) begin
            n_fail++; $display("FAIL stuff_err_counts: got err %0d done %0d expected 1 and 0", se_any, fd_any);
        end
        n_checks++;
        if ({busy_a[1000], busy_a[1676], busy_a[1677]} !== 3'b110) begin
            n_fail++;
            $display("FAIL err_recovery_busy: got %b expected 110", {busy_a[1000], busy_a[1676], busy_a[1677]});
        end
        n_checks++;
        if (st_q.size() != 17) begin
            n_fail++; $display("FAIL err_strobe_count: got %0d expected 17", st_q.size());
        end
    endtask

    task automatic test_frame_end();
        init_vec();
        sofv[0] = 1'b1;
        for (int i = 0; i < 1290; i++) ddv[i] = 1'b1;
        set_range(0, 199, 1'b0);
        sofv[1300] = 1'b1;
        set_range(1300, 1399, 1'b0);
        do_reset();
        play(1400);
        n_checks++;
        if ((st_q.size() > 12 ? {fd_q[12], 11'(st_q[12])} : 12'hfff) !== {1'b1, 11'd1276} || fd_any != 1) begin
            n_fail++; $display("FAIL frame_done: got %0d pulses expected 1 at cycle 1276", fd_any);
        end
        n_checks++;
        if ({busy_a[1276], busy_a[1277], busy_a[1300], busy_a[1301]} !== 4'b1001) begin
            n_fail++;
            $display("FAIL frame_end_busy: got %b expected 1001",
                     {busy_a[1276], busy_a[1277], busy_a[1300], busy_a[1301]});
        end
        n_checks++;
        if (st_q.size() != 14 || st_q[13] != 1376) begin
            n_fail++; $display("FAIL new_sof_strobe: got count %0d expected 14 with last at 1376", st_q.size());
        end
    endtask

    task automatic test_resync();
        int e_cyc [3] = '{205, 230, 190};
`ifdef CAN_RX_SOFT_RESYNC_EN
        int exp_c [3] = '{281, 286, 266};
`else
        int exp_c [3] = '{276, 276, 276};
`endif
        for (int t = 0; t < 3; t++) begin
            init_vec();
            sofv[0] = 1'b1;
            set_range(0, 99, 1'b0);
            set_range(e_cyc[t], 399, 1'b0);
            do_reset();
            play(300);
            n_checks++;
            if ((st_q.size() > 2 ? st_q[2] : -1) != exp_c[t]) begin
                n_fail++;
                $display("FAIL resync_edge%0d: got strobe %0d expected %0d", e_cyc[t],
                         (st_q.size() > 2 ? st_q[2] : -1), exp_c[t]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        init_vec();
        sofv[0] = 1'b1;
        set_range(0, 799, 1'b0);
        rstv[575] = 1'b1;
        do_reset();
        play(800);
        n_checks++;
        if (st_q.size() != 5 || se_any != 0 || fd_any != 0) begin
            n_fail++;
            $display("FAIL reset_mid_frame: got strobes %0d err %0d done %0d expected 5 0 0",
                     st_q.size(), se_any, fd_any);
        end
        n_checks++;
        if ({busy_a[575], busy_a[576], busy_a[799]} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_mid_busy: got %b expected 100", {busy_a[575], busy_a[576], busy_a[799]});
        end
    endtask

    initial begin
        rst = 1'b1; can_rx = 1'b0; sof_detect = 1'b1; destuff_dis = 1'b0;
        test_reset();
        test_nominal(1'b0);
        test_stuff_bit();
        test_stuff_err();
        test_frame_end();
        test_resync();
        test_nominal(1'b1);
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
